// File: rtl/flex_counter_cascade_pkg.sv
// Shared constants for the cascaded flex counter.
package flex_counter_cascade_pkg;

  // Upper bound on cascade depth checked at elaboration.
  localparam int unsigned MAX_STAGES = 8;

endpackage

// File: rtl/flex_counter_stage.sv
// One rollover counter stage: counts 1..rollover_val, wraps to 1, reports carry.
module flex_counter_stage #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    hold,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    next_flag,
  output logic                    carry
);

  localparam int unsigned W = NUM_CNT_BITS;

  logic [W-1:0] count_q, count_d;
  logic         flag_q;
  logic         at_term;

  // Terminal test is >= so a lowered rollover value still wraps cleanly.
  assign at_term = (count_q >= rollover_val);
  assign carry   = en && at_term;

  // Next count: clear dominates, hold freezes a saturated chain, rv==0 stays at 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !hold) begin
      if (at_term) begin
        count_d = (rollover_val == '0) ? '0 : W'(1);
      end else begin
        count_d = count_q + W'(1);
      end
    end
    next_flag = (count_d == rollover_val);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= next_flag;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/flex_counter_cascade.sv
// Chain of rollover counters; each stage advances when the one below wraps.
module flex_counter_cascade
  import flex_counter_cascade_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_STAGES   = 2
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               clear,
  input  logic                               count_enable,
  input  logic                               saturate,
  input  logic [NUM_STAGES*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_STAGES*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_STAGES-1:0]              rollover_flag,
  output logic                               done,
  output logic                               carry_out
);

  localparam int unsigned W = NUM_CNT_BITS;

  // Cascade depth must stay within the supported range.
  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("flex_counter_cascade: NUM_STAGES out of range 1..8");
  end

  logic [NUM_STAGES:0]   en_chain;
  logic [NUM_STAGES-1:0] next_flags;
  logic                  hold;
  logic                  done_q, done_d;

  assign en_chain[0] = count_enable;
  // A saturated chain at terminal ignores enables entirely.
  assign hold        = saturate && done_q;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    flex_counter_stage #(
      .NUM_CNT_BITS(W)
    ) u_stage (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .en           (en_chain[k]),
      .hold         (hold),
      .rollover_val (rollover_val[k*W +: W]),
      .count_out    (count_out[k*W +: W]),
      .rollover_flag(rollover_flag[k]),
      .next_flag    (next_flags[k]),
      .carry        (en_chain[k+1])
    );
  end

  // Done is the AND of every stage's next flag.
  always_comb begin
    done_d = &next_flags;
  end

  // Done register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign carry_out = en_chain[NUM_STAGES] && !saturate && !clear;

endmodule

// File: tb/tb_flex_counter_cascade.sv
// Directed test of flex_counter_cascade with 2 stages of 4 bits.
module tb_flex_counter_cascade;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic       saturate;
  logic [7:0] rollover_val;
  logic [7:0] count_out;
  logic [1:0] rollover_flag;
  logic       done;
  logic       carry_out;

  int tests_run;
  int tests_failed;

  flex_counter_cascade #(
    .NUM_CNT_BITS(4),
    .NUM_STAGES  (2)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .saturate     (saturate),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .done         (done),
    .carry_out    (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; count_enable = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic run_en(input int n);
    count_enable = 1'b1;
    repeat (n) tick();
    count_enable = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (count_out !== 8'h00 || rollover_flag !== 2'b00 || done !== 1'b0 || carry_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%h flags=%b done=%b carry=%b, want 00 00 0 0",
               count_out, rollover_flag, done, carry_out);
    end
    n_rst = 1'b1;
    tick();
    tests_run++;
    if (count_out !== 8'h00 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: count=%h done=%b, want 00 0", count_out, done);
    end
  endtask

  // 32 enabled cycles from zero reach {8,3}; checked every edge.
  task automatic test_count_full();
    logic [3:0] s0, s1;
    count_enable = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      #1;
      tests_run++;
      if (carry_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_carry cyc%0d: carry=%b want 0", i, carry_out);
      end
      tick();
      s0 = 4'((i - 1) % 8 + 1);
      s1 = 4'((i - 1) / 8);
      tests_run++;
      if (count_out !== {s1, s0} || rollover_flag !== {s1 == 4'd3, s0 == 4'd8}
          || done !== (s1 == 4'd3 && s0 == 4'd8)) begin
        tests_failed++;
        $display("FAIL count_seq edge%0d: count=%h flags=%b done=%b, want %h %b %b",
                 i, count_out, rollover_flag, done, {s1, s0},
                 {s1 == 4'd3, s0 == 4'd8}, (s1 == 4'd3 && s0 == 4'd8));
      end
    end
    // One more enabled cycle: full-chain wrap.
    #1;
    tests_run++;
    if (carry_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_carry: carry=%b want 1", carry_out);
    end
    tick();
    count_enable = 1'b0;
    tests_run++;
    if (count_out !== 8'h11 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_state: count=%h done=%b, want 11 0", count_out, done);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    run_en(32);
    saturate = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (carry_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL sat_carry cyc%0d: carry=%b want 0", i, carry_out);
      end
      tick();
      tests_run++;
      if (count_out !== 8'h38 || done !== 1'b1 || rollover_flag !== 2'b11) begin
        tests_failed++;
        $display("FAIL sat_hold cyc%0d: count=%h done=%b flags=%b, want 38 1 11",
                 i, count_out, done, rollover_flag);
      end
    end
    saturate = 1'b0;
    #1;
    tests_run++;
    if (carry_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL unsat_carry: carry=%b want 1", carry_out);
    end
    tick();
    count_enable = 1'b0;
    tests_run++;
    if (count_out !== 8'h11 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL unsat_wrap: count=%h done=%b, want 11 0", count_out, done);
    end
  endtask

  task automatic test_rv_one();
    rollover_val = 8'hF1;
    do_clear();
    count_enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (count_out !== {4'(k - 1), 4'd1} || rollover_flag[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL rv_one edge%0d: count=%h flag0=%b, want %h 1",
                 k, count_out, rollover_flag[0], {4'(k - 1), 4'd1});
      end
    end
    count_enable = 1'b0;
    rollover_val = 8'h38;
  endtask

  task automatic test_stall_clear();
    do_clear();
    run_en(32);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (count_out !== 8'h38 || rollover_flag[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall cyc%0d: count=%h flag0=%b, want 38 1", i, count_out, rollover_flag[0]);
      end
    end
    clear = 1'b1; count_enable = 1'b1;
    #1;
    tests_run++;
    if (carry_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_carry: carry=%b want 0", carry_out);
    end
    tick();
    clear = 1'b0; count_enable = 1'b0;
    tests_run++;
    if (count_out !== 8'h00 || rollover_flag !== 2'b00 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_state: count=%h flags=%b done=%b, want 00 00 0",
               count_out, rollover_flag, done);
    end
  endtask

  task automatic test_lower_rv();
    do_clear();
    run_en(6);
    tests_run++;
    if (count_out !== 8'h06) begin
      tests_failed++;
      $display("FAIL lower_pre: count=%h want 06", count_out);
    end
    rollover_val = 8'h34;
    run_en(1);
    tests_run++;
    if (count_out !== 8'h11 || rollover_flag[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lower_wrap: count=%h flag0=%b, want 11 0", count_out, rollover_flag[0]);
    end
    rollover_val = 8'h38;
  endtask

  task automatic test_async_reset();
    do_clear();
    run_en(5);
    #2;
    n_rst = 1'b0;
    #1;
    tests_run++;
    if (count_out !== 8'h00 || rollover_flag !== 2'b00 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: count=%h flags=%b done=%b, want 00 00 0",
               count_out, rollover_flag, done);
    end
    tick();
    n_rst = 1'b1;
    run_en(1);
    tests_run++;
    if (count_out !== 8'h01) begin
      tests_failed++;
      $display("FAIL post_reset: count=%h want 01", count_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_rst        = 1'b0;
    clear        = 1'b0;
    count_enable = 1'b0;
    saturate     = 1'b0;
    rollover_val = 8'h38;
    tick();
    tick();
    test_reset();
    test_count_full();
    test_saturate();
    test_rv_one();
    test_stall_clear();
    test_lower_rv();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
